// File: rtl/rotation_sequencer.sv
// rotation_sequencer: FlexBus register front-end and launch/wait controller for the rotation core
module rotation_sequencer #(
  parameter int TIMEOUT = 64
) (
  input  logic        FB_CLK,
  input  logic        bRESET,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [3:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic [31:0] v0,
  output logic [31:0] v1,
  output logic [31:0] v2,
  output logic [31:0] v3,
  output logic [31:0] r0,
  output logic [31:0] r1,
  output logic [31:0] r2,
  output logic [31:0] r3,
  output logic [3:0]  valid_v,
  output logic [3:0]  valid_r,
  input  logic [31:0] out0,
  input  logic [31:0] out1,
  input  logic [31:0] out2,
  input  logic [31:0] out3,
  input  logic        valid_result,
  output logic        busy
);
  localparam int CW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_DONE} state_t;
  state_t         state_q, state_d;
  logic [31:0]    v_q [4], v_d [4];
  logic [31:0]    r_q [4], r_d [4];
  logic [31:0]    res_q [4], res_d [4];
  logic [3:0]     vmask_q, vmask_d, rmask_q, rmask_d;
  logic           done_q, done_d, to_q, to_d, pend_q, pend_d, ack_q, ack_d;
  logic [3:0]     pend_addr_q, pend_addr_d, ra;
  logic [31:0]    rdata_q, rdata_d, stat, rd_val;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           idle, rd, res_rd, ctl_wr;
  assign {v0, v1, v2, v3} = {v_q[0], v_q[1], v_q[2], v_q[3]};
  assign {r0, r1, r2, r3} = {r_q[0], r_q[1], r_q[2], r_q[3]};
  assign rdata = rdata_q;
  assign ack = ack_q;
  // Bus decode, register updates, FSM next state and the read/ack path
  always_comb begin
    idle = state_q == S_IDLE || state_q == S_DONE;
    busy = !idle;
    valid_v = {4{state_q == S_LAUNCH}};
    valid_r = {4{state_q == S_LAUNCH}};
    rd = rd_en && !wr_en;
    res_rd = addr[3:2] == 2'b10;
    ctl_wr = wr_en && addr == 4'hC;
    stat = {20'd0, rmask_q, vmask_q, 1'b0, to_q, done_q, busy};
    ra = pend_q ? pend_addr_q : addr;
    rd_val = ra[3:2] == 2'b00 ? v_q[ra[1:0]] :
             ra[3:2] == 2'b01 ? r_q[ra[1:0]] :
             ra[3:2] == 2'b10 ? (to_q ? '1 : res_q[ra[1:0]]) :
             ra == 4'hC ? stat : '0;
    state_d = state_q;
    v_d = v_q;
    r_d = r_q;
    res_d = res_q;
    vmask_d = vmask_q;
    rmask_d = rmask_q;
    done_d = done_q;
    to_d = to_q;
    cnt_d = '0;
    if (wr_en && idle && !addr[3]) begin
      if (addr[2]) begin
        r_d[addr[1:0]] = wdata;
        rmask_d[addr[1:0]] = 1'b1;
      end else begin
        v_d[addr[1:0]] = wdata;
        vmask_d[addr[1:0]] = 1'b1;
      end
    end
    if (wr_en && state_q == S_DONE) done_d = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: if ((ctl_wr && wdata[0]) || (wr_en && &vmask_d && &rmask_d)) state_d = S_LAUNCH;
      S_LAUNCH: begin
        vmask_d = '0;
        rmask_d = '0;
        to_d = 1'b0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (valid_result) begin
          res_d[0] = out0;
          res_d[1] = out1;
          res_d[2] = out2;
          res_d[3] = out3;
          done_d = 1'b1;
          state_d = S_DONE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          to_d = 1'b1;
          done_d = 1'b1;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    pend_d = pend_q ? state_q != S_DONE : rd && res_rd && !idle;
    pend_addr_d = rd ? addr : pend_addr_q;
    if (ctl_wr && wdata[1]) begin
      vmask_d = '0;
      rmask_d = '0;
      done_d = 1'b0;
      to_d = 1'b0;
      pend_d = 1'b0;
      state_d = S_IDLE;
    end
    ack_d = wr_en || (rd && !(res_rd && !idle)) || (pend_q && state_q == S_DONE);
    rdata_d = ack_d && !wr_en ? rd_val : '0;
  end
  // State register with synchronous active-low reset clearing everything
  always_ff @(posedge FB_CLK) begin
    if (!bRESET) begin
      state_q <= S_IDLE;
      v_q <= '{default: '0};
      r_q <= '{default: '0};
      res_q <= '{default: '0};
      vmask_q <= '0;
      rmask_q <= '0;
      done_q <= 1'b0;
      to_q <= 1'b0;
      pend_q <= 1'b0;
      pend_addr_q <= '0;
      ack_q <= 1'b0;
      rdata_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      v_q <= v_d;
      r_q <= r_d;
      res_q <= res_d;
      vmask_q <= vmask_d;
      rmask_q <= rmask_d;
      done_q <= done_d;
      to_q <= to_d;
      pend_q <= pend_d;
      pend_addr_q <= pend_addr_d;
      ack_q <= ack_d;
      rdata_q <= rdata_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_rotation_sequencer.sv
// tb_rotation_sequencer: randomized directed bench for rotation_sequencer against a register-map model
module tb_rotation_sequencer;
  logic        FB_CLK = 1'b0;
  logic        bRESET = 1'b0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [3:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] out0 = '0, out1 = '0, out2 = '0, out3 = '0;
  logic        valid_result = 1'b0;
  logic [31:0] rdata, v0, v1, v2, v3, r0, r1, r2, r3;
  logic        ack, busy;
  logic [3:0]  valid_v, valid_r;
  int total = 0;
  int bad = 0;
  logic [31:0] mv [8];
  logic [31:0] mres [4];
  logic [7:0]  mmask;
  logic        mdone, mto, mbusy;

  rotation_sequencer #(.TIMEOUT(16)) dut (
    .FB_CLK(FB_CLK), .bRESET(bRESET), .wr_en(wr_en), .rd_en(rd_en), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ack(ack), .v0(v0), .v1(v1), .v2(v2), .v3(v3), .r0(r0), .r1(r1), .r2(r2), .r3(r3),
    .valid_v(valid_v), .valid_r(valid_r), .out0(out0), .out1(out1), .out2(out2), .out3(out3),
    .valid_result(valid_result), .busy(busy)
  );

  always #5 FB_CLK = ~FB_CLK;

  function automatic logic [31:0] stat_m();
    return {20'd0, mmask[7:4], mmask[3:0], 1'b0, mto, mdone, mbusy};
  endfunction

  function automatic logic [31:0] getop(input int i);
    case (i)
      0: return v0;
      1: return v1;
      2: return v2;
      3: return v3;
      4: return r0;
      5: return r1;
      6: return r2;
      default: return r3;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge FB_CLK);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    logic launch;
    wr_en = 1'b1;
    addr = a;
    wdata = d;
    step();
    wr_en = 1'b0;
    if (!mbusy) begin
      if (a < 8) begin
        mv[a[2:0]] = d;
        mmask[a[2:0]] = 1'b1;
      end
      mdone = 1'b0;
    end
    launch = !mbusy && (mmask == 8'hFF || (a == 4'hC && d[0])) && !(a == 4'hC && d[1]);
    if (a == 4'hC && d[1]) begin
      mmask = '0;
      mdone = 1'b0;
      mto = 1'b0;
      mbusy = 1'b0;
    end
    if (launch) begin
      mbusy = 1'b1;
      mto = 1'b0;
    end
    chk("wr_ack", ack, 1);
    chk("wr_valid_v", valid_v, launch ? 4'hF : 4'h0);
    chk("wr_valid_r", valid_r, launch ? 4'hF : 4'h0);
    chk("wr_busy", busy, mbusy);
    if (launch) mmask = '0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] exp, input string tag);
    rd_en = 1'b1;
    addr = a;
    step();
    rd_en = 1'b0;
    chk({tag, "_ack"}, ack, 1);
    chk(tag, rdata, exp);
    step();
    chk({tag, "_ack_drop"}, ack, 0);
  endtask

  initial begin
    int p [8];
    int k, t, j, dly, fin;
    logic tmo;
    logic [31:0] nr [4];
    logic [31:0] x;
    for (int i = 0; i < 8; i++) mv[i] = '0;
    for (int i = 0; i < 4; i++) mres[i] = '0;
    mmask = '0;
    mdone = 1'b0;
    mto = 1'b0;
    mbusy = 1'b0;
    step();
    step();
    chk("rst_ack", ack, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid_v", valid_v, 0);
    chk("rst_v0", v0, 0);
    bRESET = 1'b1;
    rd(4'hC, 32'h0, "rst_stat");
    for (int run = 0; run < 4; run++) begin
      for (int i = 0; i < 8; i++) p[i] = i;
      for (int i = 7; i > 0; i--) begin
        k = $urandom_range(0, i);
        t = p[i];
        p[i] = p[k];
        p[k] = t;
      end
      for (int i = 0; i < 8; i++) begin
        wr(4'(p[i]), $urandom);
        if (i == 3) rd(4'hC, stat_m(), "stat_masks");
      end
      for (int i = 0; i < 8; i++) chk("operand", getop(i), mv[i]);
      step();
      chk("wait_valid_v", valid_v, 0);
      chk("wait_busy", busy, 1);
      tmo = run % 2 == 1;
      dly = $urandom_range(5, 14);
      j = $urandom_range(0, 3);
      fin = tmo ? 16 : dly + 1;
      for (int i = 0; i < 4; i++) nr[i] = $urandom;
      for (int w = 0; w <= fin + 1; w++) begin
        wr_en = w == 0;
        wdata = 32'hAAAA;
        rd_en = w == 1 || w == 3 || w == 5;
        addr = w == 3 ? 4'hC : w == 5 ? 4'(8 + j) : 4'h0;
        valid_result = !tmo && w == dly;
        {out0, out1, out2, out3} = {nr[0], nr[1], nr[2], nr[3]};
        step();
        wr_en = 1'b0;
        rd_en = 1'b0;
        valid_result = 1'b0;
        if (w == fin - 1) begin
          mbusy = 1'b0;
          mdone = 1'b1;
          mto = tmo;
          if (!tmo) for (int i = 0; i < 4; i++) mres[i] = nr[i];
        end
        chk("loop_ack", ack, w == 0 || w == 1 || w == 3 || w == fin);
        if (w == 1) chk("busy_wr_discard", rdata, mv[0]);
        if (w == 3) chk("stat_wait", rdata, stat_m());
        if (w == fin) chk("stall_rd", rdata, tmo ? 32'hFFFF_FFFF : mres[j]);
        chk("loop_busy", busy, mbusy);
      end
      rd(4'hC, stat_m(), "stat_done");
      j = $urandom_range(0, 3);
      rd(4'(8 + j), tmo ? 32'hFFFF_FFFF : mres[j], "result_rd");
      chk("v0_kept", v0, mv[0]);
    end
    wr(4'hC, 32'h1);
    step();
    chk("start_busy", busy, 1);
    wr(4'hC, 32'h2);
    valid_result = 1'b1;
    {out0, out1, out2, out3} = {$urandom, $urandom, $urandom, $urandom};
    step();
    valid_result = 1'b0;
    rd(4'hC, stat_m(), "stat_clear");
    rd(4'h9, mres[1], "res_after_clear");
    x = $urandom;
    wr_en = 1'b1;
    rd_en = 1'b1;
    addr = 4'h2;
    wdata = x;
    step();
    wr_en = 1'b0;
    rd_en = 1'b0;
    mv[2] = x;
    mmask[2] = 1'b1;
    chk("both_ack", ack, 1);
    step();
    chk("both_ack_once", ack, 0);
    rd(4'h2, x, "both_wr_data");
    rd(4'hC, stat_m(), "both_stat");
    wr(4'hE, $urandom);
    rd(4'hE, 32'h0, "rd_e");
    rd(4'hD, 32'h0, "rd_d");
    rd(4'hF, 32'h0, "rd_f");
    wr(4'hC, 32'h1);
    step();
    bRESET = 1'b0;
    step();
    chk("midrst_busy", busy, 0);
    chk("midrst_v2", v2, 0);
    chk("midrst_valid_v", valid_v, 0);
    chk("midrst_ack", ack, 0);
    bRESET = 1'b1;
    for (int i = 0; i < 8; i++) mv[i] = '0;
    for (int i = 0; i < 4; i++) mres[i] = '0;
    mmask = '0;
    mdone = 1'b0;
    mto = 1'b0;
    mbusy = 1'b0;
    rd(4'hC, stat_m(), "midrst_stat");
    rd(4'h8, mres[0], "midrst_res");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
